// File: rtl/peak_meter_pkg.sv
// Shared audio constants and types for the stereo peak meter.
//   SAMPLE_W    : width of a signed mixer sample (18)
//   MAG_W       : width of the saturated magnitude (17)
//   LEVEL_W     : width of a displayed meter level (8)
//   CLIP_THRESH : magnitude that counts as a clipped sample (131071)
//   chan_state_e: per-channel meter state
//   cnt_width() : counter width for a sample-count parameter, never below 1 bit
package peak_meter_pkg;

  localparam int SAMPLE_W = 18;
  localparam int MAG_W    = 17;
  localparam int LEVEL_W  = 8;

  localparam logic [MAG_W-1:0] CLIP_THRESH = 17'd131071;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // level is 0, nothing held
    ST_HOLD  = 2'd1,  // peak frozen while hold counter runs down
    ST_DECAY = 2'd2   // level steps down once per decay period
  } chan_state_e;

  // A parameter of 1 still needs a 1-bit counter (it only ever holds 0).
  function automatic int cnt_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/peak_channel.sv
// One meter channel: saturating magnitude stage, then level/clip tracking.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   ready_i  : sample strobe; captures sample_i into the magnitude register
//   update_i : magnitude register holds a sample to be applied this cycle
//   sample_i : signed two's-complement sample
//   level_o  : held / decaying peak level
//   clip_o   : clip indicator, stretched for CLIP_HOLD samples
module peak_channel
  import peak_meter_pkg::*;
#(
  parameter int HOLD_SAMPLES  = 4800,
  parameter int DECAY_SAMPLES = 480,
  parameter int CLIP_HOLD     = 24000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready_i,
  input  logic                update_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [LEVEL_W-1:0]  level_o,
  output logic                clip_o
);

  localparam int HOLD_W  = cnt_width(HOLD_SAMPLES);
  localparam int DECAY_W = cnt_width(DECAY_SAMPLES);
  localparam int CLIP_W  = cnt_width(CLIP_HOLD);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_SAMPLES - 1);
  localparam logic [CLIP_W-1:0]  CLIP_LAST  = CLIP_W'(CLIP_HOLD - 1);

  // ---------------- stage 1: magnitude ----------------
  logic [SAMPLE_W-1:0] abs_raw;
  logic [MAG_W-1:0]    mag_d, mag_q;

  always_comb begin
    abs_raw = sample_i[SAMPLE_W-1] ? (~sample_i + 1'b1) : sample_i;
    // Only -131072 sets the top bit of abs_raw; it saturates to full scale.
    mag_d   = abs_raw[SAMPLE_W-1] ? CLIP_THRESH : abs_raw[MAG_W-1:0];
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       mag_q <= '0;
    else if (ready_i) mag_q <= mag_d;
  end

  logic [LEVEL_W-1:0] sample_level;
  logic               sample_clip;

  assign sample_level = mag_q[MAG_W-1 -: LEVEL_W];
  assign sample_clip  = (mag_q == CLIP_THRESH);

  // ---------------- stage 2: level FSM and clip stretch ----------------
  chan_state_e        state_d, state_q;
  logic [LEVEL_W-1:0] level_d, level_q;
  logic [HOLD_W-1:0]  hold_cnt_d, hold_cnt_q;
  logic [DECAY_W-1:0] decay_cnt_d, decay_cnt_q;
  logic               clip_d, clip_q;
  logic [CLIP_W-1:0]  clip_cnt_d, clip_cnt_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d     = state_q;
    level_d     = level_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    clip_d      = clip_q;
    clip_cnt_d  = clip_cnt_q;

    if (update_i) begin
      // A new or equal non-zero peak always wins and restarts the hold.
      if ((sample_level >= level_q) && (sample_level != '0)) begin
        state_d     = ST_HOLD;
        level_d     = sample_level;
        hold_cnt_d  = HOLD_LAST;
        decay_cnt_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_HOLD: begin
            if (hold_cnt_q == '0) begin
              state_d     = ST_DECAY;
              decay_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q - 1'b1;
            end
          end
          ST_DECAY: begin
            // Level is at least 1 in DECAY; stepping from 1 lands in IDLE,
            // so the level can never wrap below 0.
            if (decay_cnt_q == DECAY_LAST) begin
              decay_cnt_d = '0;
              level_d     = level_q - 1'b1;
              if (level_q == LEVEL_W'(1)) state_d = ST_IDLE;
            end else begin
              decay_cnt_d = decay_cnt_q + 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      if (sample_clip) begin
        clip_d     = 1'b1;
        clip_cnt_d = CLIP_LAST;
      end else if (clip_cnt_q != '0) begin
        clip_cnt_d = clip_cnt_q - 1'b1;
      end else begin
        clip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      clip_q      <= 1'b0;
      clip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      clip_q      <= clip_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign level_o = level_q;
  assign clip_o  = clip_q;

endmodule

// File: rtl/peak_meter.sv
// Stereo peak meter for the mixer output: per-channel held/decaying levels and
// stretched clip flags, updated two cycles after each sample strobe.
//   clock, reset             : system clock / asynchronous active-low reset
//   ready                    : one-cycle sample strobe, back-to-back allowed
//   audio_left, audio_right  : signed 18-bit samples, valid with ready
//   level_left, level_right  : 8-bit peak levels
//   clip_left, clip_right    : clip indicators
//   meter_valid              : one-cycle pulse when levels/clips were updated
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int HOLD_SAMPLES  = 4800,
  parameter int DECAY_SAMPLES = 480,
  parameter int CLIP_HOLD     = 24000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  output logic [LEVEL_W-1:0]  level_left,
  output logic [LEVEL_W-1:0]  level_right,
  output logic                clip_left,
  output logic                clip_right,
  output logic                meter_valid
);

  // Valid bits track each strobe through the two stages; clearing them on
  // reset drops any in-flight sample.
  logic mag_valid_q;
  logic meter_valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mag_valid_q   <= 1'b0;
      meter_valid_q <= 1'b0;
    end else begin
      mag_valid_q   <= ready;
      meter_valid_q <= mag_valid_q;
    end
  end

  assign meter_valid = meter_valid_q;

  peak_channel #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_SAMPLES(DECAY_SAMPLES),
    .CLIP_HOLD    (CLIP_HOLD)
  ) u_left (
    .clock   (clock),
    .reset   (reset),
    .ready_i (ready),
    .update_i(mag_valid_q),
    .sample_i(audio_left),
    .level_o (level_left),
    .clip_o  (clip_left)
  );

  peak_channel #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_SAMPLES(DECAY_SAMPLES),
    .CLIP_HOLD    (CLIP_HOLD)
  ) u_right (
    .clock   (clock),
    .reset   (reset),
    .ready_i (ready),
    .update_i(mag_valid_q),
    .sample_i(audio_right),
    .level_o (level_right),
    .clip_o  (clip_right)
  );

endmodule

// File: tb/tb_peak_meter.sv
// Directed bench for peak_meter with HOLD_SAMPLES=4, DECAY_SAMPLES=2, CLIP_HOLD=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_peak_meter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic [17:0] audio_left;
  logic [17:0] audio_right;
  logic [7:0]  level_left;
  logic [7:0]  level_right;
  logic        clip_left;
  logic        clip_right;
  logic        meter_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  peak_meter #(
    .HOLD_SAMPLES (4),
    .DECAY_SAMPLES(2),
    .CLIP_HOLD    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .level_left (level_left),
    .level_right(level_right),
    .clip_left  (clip_left),
    .clip_right (clip_right),
    .meter_valid(meter_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where the sample's
  // update is visible (two rising edges after the strobe).
  task automatic send(input logic [17:0] l, input logic [17:0] r);
    ready       = 1'b1;
    audio_left  = l;
    audio_right = r;
    @(negedge clock);
    ready       = 1'b0;
    audio_left  = '0;
    audio_right = '0;
    check("mv_early", 32'(meter_valid), 32'd0);
    @(negedge clock);
    check("mv_pulse", 32'(meter_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lvl_l"}, 32'(level_left), 32'd0);
    check({tag, "_lvl_r"}, 32'(level_right), 32'd0);
    check({tag, "_clip_l"}, 32'(clip_left), 32'd0);
    check({tag, "_clip_r"}, 32'(clip_right), 32'd0);
    check({tag, "_mv"}, 32'(meter_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Level after each of 12 zero samples following a peak of 100.
  int decay_exp [12] = '{100, 100, 100, 100, 100, 99, 99, 98, 98, 97, 97, 96};
  // Level seen on each falling edge of the back-to-back burst.
  int burst_lvl [8]  = '{0, 0, 10, 20, 30, 30, 40, 40};
  int after_exp [6]  = '{120, 120, 120, 120, 120, 119};

  initial begin
    reset       = 1'b0;
    ready       = 1'b0;
    audio_left  = '0;
    audio_right = '0;

    // ---- reset state ----
    @(negedge clock);
    @(negedge clock);
    check_all_zero("in_reset");
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("post_reset");

    // ---- peak 51200 (L=100), hold then decay ----
    send(18'h0C800, 18'h00000);
    check("pk_lvl_l", 32'(level_left), 32'd100);
    check("pk_lvl_r", 32'(level_right), 32'd0);
    for (int i = 0; i < 12; i++) begin
      send(18'h00000, 18'h00000);
      check($sformatf("decay%0d_l", i + 1), 32'(level_left), 32'(decay_exp[i]));
      check($sformatf("decay%0d_r", i + 1), 32'(level_right), 32'd0);
    end

    // ---- new peak interrupts decay ----
    do_reset();
    send(18'h0C800, 18'h00000);
    for (int i = 0; i < 8; i++) send(18'h00000, 18'h00000);
    check("pre_repeak", 32'(level_left), 32'd98);
    send(18'h0F000, 18'h00000);  // 61440 -> L=120
    check("repeak", 32'(level_left), 32'd120);
    for (int i = 0; i < 6; i++) begin
      send(18'h00000, 18'h00000);
      check($sformatf("rehold%0d", i + 1), 32'(level_left), 32'(after_exp[i]));
    end

    // ---- clip on -131072 and clip stretch ----
    do_reset();
    send(18'h20000, 18'h00000);  // -131072
    check("clip_lvl", 32'(level_left), 32'd255);
    check("clip_l", 32'(clip_left), 32'd1);
    check("clip_r", 32'(clip_right), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(18'h00000, 18'h00000);
      check($sformatf("clip_hold%0d", i + 1), 32'(clip_left), (i < 7) ? 32'd1 : 32'd0);
      check($sformatf("clip_r%0d", i + 1), 32'(clip_right), 32'd0);
    end
    check("clip_decay_lvl", 32'(level_left), 32'd253);
    send(18'h1FFFE, 18'h1FFFF);  // 131070 (no clip) / 131071 (clip)
    check("near_clip_l", 32'(clip_left), 32'd0);
    check("near_lvl_l", 32'(level_left), 32'd255);
    check("pos_clip_r", 32'(clip_right), 32'd1);
    check("pos_lvl_r", 32'(level_right), 32'd255);
    send(18'h20001, 18'h00000);  // -131071
    check("neg_clip_l", 32'(clip_left), 32'd1);

    // ---- back-to-back strobes: L = 10, 20, 30, 5, 40 ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_mv%0d", i), 32'(meter_valid), (i >= 2 && i <= 6) ? 32'd1 : 32'd0);
      check($sformatf("b2b_lvl%0d", i), 32'(level_left), 32'(burst_lvl[i]));
      ready = (i < 5);
      case (i)
        0: audio_left = 18'h01400;  // L=10
        1: audio_left = 18'h02800;  // L=20
        2: audio_left = 18'h03C00;  // L=30
        3: audio_left = 18'h00A00;  // L=5
        4: audio_left = 18'h05000;  // L=40
        default: audio_left = 18'h00000;
      endcase
      @(negedge clock);
    end

    // ---- reset mid-pipeline discards the in-flight sample ----
    ready      = 1'b1;
    audio_left = 18'h0C800;
    @(negedge clock);
    ready      = 1'b0;
    audio_left = '0;
    reset      = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("flush_mv%0d", i), 32'(meter_valid), 32'd0);
      check($sformatf("flush_lvl%0d", i), 32'(level_left), 32'd0);
    end
    send(18'h00000, 18'h00000);
    check("flush_next_lvl", 32'(level_left), 32'd0);
    @(negedge clock);
    check("flush_next_mv_low", 32'(meter_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
